// File: rtl/elevator_pkg.sv
// Shared elevator definitions: default sizing, floor-code type and the
// call-encoder state encoding used by the request producer.
package elevator_pkg;

  localparam int unsigned DEF_N_FLOORS = 8;
  localparam int unsigned DEF_FLOOR_W  = 3;

  typedef logic [DEF_FLOOR_W-1:0] floor_t;

  typedef enum logic {
    ENC_IDLE  = 1'b0,
    ENC_OFFER = 1'b1
  } enc_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: lowest set bit of req at or above ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  int unsigned k;
  logic [N-1:0] sh;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    sh    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k  = (32'(ptr) + i) % N;
      sh = req >> k;
      if (!found && sh[0]) begin
        found = 1'b1;
        idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/call_encoder.sv
// Call-button front end: synchronises buttons, keeps per-floor call lamps and
// hands unqueued calls to the request buffer round-robin over valid/ready.
module call_encoder
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS = DEF_N_FLOORS,
  parameter int unsigned FLOOR_W  = DEF_FLOOR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] btn,
  output logic                req_valid,
  output logic [FLOOR_W-1:0]  req_floor,
  input  logic                req_ready,
  input  logic                arrive_valid,
  input  logic [FLOOR_W-1:0]  arrive_floor,
  output logic [N_FLOORS-1:0] pending
);

  logic [N_FLOORS-1:0] sync1, sync2, sync2_d;
  logic [N_FLOORS-1:0] press_evt, arr_mask, offering, cand;
  logic [N_FLOORS-1:0] pending_n, queued, queued_n, acc_mask;
  logic [FLOOR_W-1:0]  ptr, ptr_n, floor_n, pick_idx;
  logic                valid_n, pick_found, accept_c;
  enc_state_e          state, state_n;

  // Two-stage synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign press_evt = sync2 & ~sync2_d;

  // Out-of-range arrival codes produce an empty mask.
  always_comb begin
    arr_mask = '0;
    if (arrive_valid && (32'(arrive_floor) < N_FLOORS))
      arr_mask = N_FLOORS'(1) << arrive_floor;
  end

  assign offering  = req_valid ? (N_FLOORS'(1) << req_floor) : '0;
  assign cand      = pending & ~queued & ~offering;
  assign acc_mask  = accept_c ? (N_FLOORS'(1) << req_floor) : '0;
  // Arrival dominates a same-cycle press, and blocks queueing a served floor.
  assign pending_n = (pending | press_evt) & ~arr_mask;
  assign queued_n  = (queued | (acc_mask & pending_n)) & ~arr_mask;

  rr_pick #(
    .N (N_FLOORS),
    .W (FLOOR_W)
  ) u_pick (
    .req   (cand),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ENC_IDLE;
      req_valid <= 1'b0;
      req_floor <= '0;
      ptr       <= '0;
      pending   <= '0;
      queued    <= '0;
    end else begin
      state     <= state_n;
      req_valid <= valid_n;
      req_floor <= floor_n;
      ptr       <= ptr_n;
      pending   <= pending_n;
      queued    <= queued_n;
    end
  end

  // Offer is held until accepted; a bubble in IDLE separates transfers.
  always_comb begin
    state_n  = state;
    valid_n  = req_valid;
    floor_n  = req_floor;
    ptr_n    = ptr;
    accept_c = 1'b0;
    case (state)
      ENC_IDLE: begin
        if (pick_found) begin
          floor_n = pick_idx;
          valid_n = 1'b1;
          state_n = ENC_OFFER;
        end
      end
      ENC_OFFER: begin
        if (req_ready) begin
          accept_c = 1'b1;
          valid_n  = 1'b0;
          state_n  = ENC_IDLE;
          if (req_floor == FLOOR_W'(N_FLOORS - 1))
            ptr_n = '0;
          else
            ptr_n = req_floor + FLOOR_W'(1);
        end
      end
      default: state_n = ENC_IDLE;
    endcase
  end

endmodule

// File: tb/tb_call_encoder.sv
// Directed bench for call_encoder: latency, round-robin order, backpressure,
// reset mid-offer and arrival/press interactions.
module tb_call_encoder;
  import elevator_pkg::*;

  localparam int unsigned N = DEF_N_FLOORS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic         req_ready = 1'b0;
  logic         arrive_valid = 1'b0;
  floor_t       arrive_floor = '0;
  logic         req_valid;
  floor_t       req_floor;
  logic [N-1:0] pending;

  call_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .req_ready    (req_ready),
    .arrive_valid (arrive_valid),
    .arrive_floor (arrive_floor),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  floor_t xq[$];
  int     xt[$];

  // Transfer log: floor and cycle of every completed handshake.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (req_valid && req_ready) begin
      xq.push_back(req_floor);
      xt.push_back(cyc);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic arrive(input floor_t f);
    arrive_valid = 1'b1;
    arrive_floor = f;
    tick();
    arrive_valid = 1'b0;
  endtask

  initial begin
    int base;
    int bad;

    // Reset state
    tick(3);
    check("rst_valid", int'(req_valid), 0);
    check("rst_floor", int'(req_floor), 0);
    check("rst_pending", int'(pending), 0);
    rst = 1'b0;
    tick();

    // Single call on floor 3 with latency checks
    req_ready = 1'b1;
    base = xq.size();
    btn = 8'h08;
    tick(2);
    check("single_pend_c2", int'(pending), 8'h00);
    tick();
    check("single_pend_c3", int'(pending), 8'h08);
    check("single_valid_c3", int'(req_valid), 0);
    tick();
    check("single_valid_c4", int'(req_valid), 1);
    check("single_floor_c4", int'(req_floor), 3);
    tick();
    check("single_valid_c5", int'(req_valid), 0);
    check("single_nxfer", xq.size() - base, 1);
    check("single_xfloor", int'(xq[base]), 3);
    tick(5);
    btn = '0;
    tick(4);
    check("single_nodup", xq.size() - base, 1);
    check("single_pend_held", int'(pending), 8'h08);
    arrive(3);
    check("single_pend_clr", int'(pending), 8'h00);
    tick(3);
    check("single_after_clr", xq.size() - base, 1);

    // Reset while floor 5 is on the bus
    req_ready = 1'b0;
    btn = 8'h20;
    tick(4);
    check("rstoff_valid_pre", int'(req_valid), 1);
    check("rstoff_floor_pre", int'(req_floor), 5);
    btn = '0;
    rst = 1'b1;
    #1;
    check("rstoff_valid_async", int'(req_valid), 0);
    check("rstoff_pend_async", int'(pending), 0);
    tick(2);
    rst = 1'b0;
    req_ready = 1'b1;
    base = xq.size();
    tick(10);
    check("rstoff_no_req", xq.size() - base, 0);
    check("rstoff_valid_post", int'(req_valid), 0);

    // Round-robin from pointer 0: floors 1, 2, 6 two cycles apart
    base = xq.size();
    btn = 8'h46;
    tick(4);
    check("rr_first_valid", int'(req_valid), 1);
    check("rr_first_floor", int'(req_floor), 1);
    tick(6);
    btn = '0;
    check("rr_nxfer", xq.size() - base, 3);
    if (xq.size() - base == 3) begin
      check("rr_x0", int'(xq[base]), 1);
      check("rr_x1", int'(xq[base+1]), 2);
      check("rr_x2", int'(xq[base+2]), 6);
      check("rr_gap01", xt[base+1] - xt[base], 2);
      check("rr_gap12", xt[base+2] - xt[base+1], 2);
    end
    check("rr_pending", int'(pending), 8'h46);
    btn = 8'h01;
    tick(4);
    check("rr_wrap_floor", int'(req_floor), 0);
    tick();
    btn = '0;
    check("rr_wrap_nxfer", xq.size() - base, 4);
    if (xq.size() - base == 4) check("rr_wrap_x3", int'(xq[base+3]), 0);
    arrive(0);
    arrive(1);
    arrive(2);
    arrive(6);
    check("rr_pend_clr", int'(pending), 0);
    tick(3);

    // Backpressure: floor 4 held on the bus, re-press ignored
    req_ready = 1'b0;
    base = xq.size();
    btn = 8'h10;
    tick(4);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(req_valid === 1'b1 && req_floor === floor_t'(4))) bad++;
      if (i == 6)  btn = '0;
      if (i == 10) btn = 8'h10;
      tick();
    end
    check("bp_stable_bad_cycles", bad, 0);
    check("bp_pending", int'(pending), 8'h10);
    check("bp_no_xfer", xq.size() - base, 0);
    req_ready = 1'b1;
    tick(8);
    check("bp_nxfer", xq.size() - base, 1);
    if (xq.size() - base == 1) check("bp_xfloor", int'(xq[base]), 4);
    check("bp_valid_after", int'(req_valid), 0);
    btn = '0;
    arrive(4);
    check("bp_pend_clr", int'(pending), 0);
    tick(3);

    // Arrival coincides with the synchronised press event of floor 2
    base = xq.size();
    btn = 8'h04;
    tick(2);
    arrive_valid = 1'b1;
    arrive_floor = 3'd2;
    tick();
    arrive_valid = 1'b0;
    check("conf_pending", int'(pending), 0);
    tick(6);
    check("conf_no_xfer", xq.size() - base, 0);
    check("conf_valid", int'(req_valid), 0);
    btn = '0;
    tick(3);

    // Floor 4 served in the very cycle its offer is accepted
    req_ready = 1'b0;
    base = xq.size();
    btn = 8'h10;
    tick(4);
    check("serve_valid", int'(req_valid), 1);
    check("serve_floor", int'(req_floor), 4);
    tick(3);
    req_ready = 1'b1;
    arrive_valid = 1'b1;
    arrive_floor = 3'd4;
    tick();
    arrive_valid = 1'b0;
    check("serve_pending", int'(pending), 0);
    check("serve_valid_after", int'(req_valid), 0);
    check("serve_nxfer", xq.size() - base, 1);
    btn = '0;
    tick(3);
    btn = 8'h10;
    tick(4);
    check("serve_repress_valid", int'(req_valid), 1);
    check("serve_repress_floor", int'(req_floor), 4);
    tick();
    check("serve_repress_nxfer", xq.size() - base, 2);
    if (xq.size() - base == 2) check("serve_repress_x", int'(xq[base+1]), 4);
    btn = '0;
    arrive(4);
    check("serve_final_pend", int'(pending), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/call_encoder.md
Name: call_encoder

Overview:
- Producer end of the floor-request queue interface.
- Samples raw hall/cab call buttons and keeps one pending lamp bit per floor.
- Picks pending, not-yet-queued floors round-robin and pushes each as a 3-bit floor code into the request buffer with a valid/ready handshake.
- Clears a floor's call when the lift controller reports arrival at that floor.

Parameters:
- N_FLOORS, 8, number of floors; one button per floor.
- FLOOR_W, 3, width of a floor code; must satisfy 2^FLOOR_W >= N_FLOORS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn  in  N_FLOORS  raw call buttons, asynchronous, level high = pressed.
- req_valid  out  1  floor request offered to the buffer.
- req_floor  out  FLOOR_W  floor code offered; meaningful only while req_valid=1.
- req_ready  in  1  buffer can accept (not full).
- arrive_valid  in  1  lift controller has stopped at a floor and served it (single-cycle pulse).
- arrive_floor  in  FLOOR_W  floor served; ignored unless arrive_valid=1.
- pending  out  N_FLOORS  call lamps: floors called and not yet served.

Behaviour:
- Reset (asynchronous, active-high):
  - req_valid=0, req_floor=0, pending=0, queued=0.
  - Round-robin pointer=0, state=IDLE, synchronizer and edge registers=0.
- Input capture:
  - Each btn bit passes through a 2-FF synchronizer, then a rising-edge detector.
  - A held button produces one event only; re-pressing after release produces a new event.
- pending[i]:
  - Set on a press event for floor i.
  - Cleared when arrive_valid=1 and arrive_floor=i.
  - Press and arrival for the same floor in the same cycle: arrival wins, bit stays 0.
  - A press on a floor that is already pending is ignored; no duplicate request.
- queued[i] (internal): floor i has been handed to the buffer. Cleared together with pending[i] on arrival.
- Candidates: pending & ~queued & ~offering, where offering masks the floor currently on the bus.
- FSM, states IDLE and OFFER:
  - IDLE: if any candidate exists, pick the first at or above the pointer, wrapping modulo N_FLOORS. Load req_floor, set req_valid=1, go to OFFER.
  - OFFER: hold req_valid and req_floor stable until a cycle where req_ready=1. In that cycle the transfer completes.
    - Set queued[req_floor], but only if pending[req_floor] is still 1 after this cycle's arrival update.
    - Next cycle: req_valid=0, pointer=(req_floor+1) mod N_FLOORS, state=IDLE.
  - Never withdraw an offer: req_valid does not drop before acceptance, even if the offered floor is served meanwhile.
- Throughput: at most one request per 2 cycles, because of the IDLE bubble.
- Latency: a btn rising edge at cycle 0 gives pending set at cycle 3 and req_valid at cycle 4 when the FSM is IDLE.
- Arrival codes >= N_FLOORS are ignored.
- Buffer full: req_ready=0 holds OFFER indefinitely. Presses keep accumulating in pending, with no loss and no duplicates.
- arrive_valid may arrive in any state and never affects req_valid/req_floor.

Decomposition:
- Shared package elevator_pkg holds:
  - N_FLOORS and FLOOR_W defaults.
  - The call_encoder state encoding (IDLE, OFFER).
  - The floor-code type, also used by the buffer and the lift FSM.
- One sub-module: rr_pick. Combinational round-robin first-set finder taking a request vector and a pointer, returning found and index. It is reusable by the lift FSM for nearest-call search.

Test Plan:
- Reset mid-OFFER (floor 5 on the bus): assert rst -> req_valid=0, pending=0 immediately. After release, no request until a new press.
- Single call: press btn[3] for 10 cycles, req_ready=1 -> pending=0x08 at cycle 3; one transfer of req_floor=3. Then arrive_valid with floor 3 -> pending=0x00.
- Round-robin: btn[1], btn[6], btn[2] pressed in the same cycle, pointer=0, ready=1 -> transfers in order 1, 2, 6, each 2 cycles apart. Pointer wraps to 7, then next press on btn[0] gives 0.
- Backpressure: press btn[4], hold req_ready=0 for 20 cycles -> req_valid=1 and req_floor=4 stable throughout. Re-press btn[4] gives no second request. Raise ready -> exactly one transfer.
- Same-cycle conflict: arrive floor 2 together with the synchronized press event of floor 2 -> pending[2]=0, no request.
- Served during offer: arrive floor 4 while floor 4 is offered -> pending[4]=0 and the offer still completes. queued[4] stays 0, so a later press of btn[4] is requested again.
